// File: rtl/avalon_pkg.sv
// Shared Avalon-MM definitions.
//   avl_state_t        : responder handshake FSM states
//   MIPS_RESET_VECTOR  : byte address fetched first after CPU reset; the boot
//                        RAM window is normally based here.
package avalon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } avl_state_t;

    localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC0_0000;

    // Width of one data word and of one byte lane.
    localparam int WORD_BITS = 32;
    localparam int LANE_BITS = 8;
    localparam int NUM_LANES = WORD_BITS / LANE_BITS;

endpackage

// File: rtl/avalon_ram_array.sv
// Byte-enabled single-port word RAM with synchronous (registered) read.
// Ports:
//   clk   : clock, rising edge
//   we    : write enable for the word at addr
//   be    : byte lanes written when we is high
//   addr  : word index
//   wdata : write data
//   rdata : word at addr, registered (old contents on a same-edge write)
// Contents power up as zero.
module avalon_ram_array
    import avalon_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter     INIT_FILE   = "",
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [NUM_LANES-1:0] be,
    input  logic [AW-1:0]        addr,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [WORD_BITS-1:0] rdata
);

    logic [WORD_BITS-1:0] mem [DEPTH_WORDS];

    initial begin
        for (int w = 0; w < DEPTH_WORDS; w++) begin
            mem[w] = '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int lane = 0; lane < NUM_LANES; lane++) begin
            if (we && be[lane]) begin
                mem[addr][lane*LANE_BITS +: LANE_BITS] <= wdata[lane*LANE_BITS +: LANE_BITS];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM responder: word-organised, byte-enabled RAM behind a fixed number
// of wait states. Each transfer stalls WAIT_CYCLES cycles, is accepted, then
// spends one DONE cycle before the next request is looked at.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   address     : byte address (bits [1:0] ignored)
//   read, write : request strobes, held by the master while waitrequest is high
//   byteenable  : write byte lanes
//   writedata   : write data
//   waitrequest : stall, forced high during reset
//   readdata    : read result, valid the cycle after acceptance and held
//                 until the next accepted read
module avalon_mem_responder
    import avalon_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = MIPS_RESET_VECTOR,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_LIMIT = 4'(WAIT_CYCLES);

    avl_state_t  state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic        rd_pending_reg;     // a read was accepted on the last edge
    logic        rd_oor_reg;         // ...and it was outside the window
    logic [31:0] readdata_hold_reg;

    logic        req;
    logic        accept;
    logic        wait_req;
    logic [31:0] offset;
    logic        in_range;
    logic [AW-1:0] word_idx;
    logic        ram_we;
    logic        rd_accept;
    logic [31:0] ram_rdata;
    logic [31:0] readdata_int;

    assign req = read | write;

    // Unsigned wrap makes addresses below BASE_ADDR land far above the span.
    assign offset   = address - BASE_ADDR;
    assign in_range = offset < SPAN_BYTES;
    assign word_idx = offset[AW+1:2];

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        wait_req   = 1'b1;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        wait_req   = 1'b0;
                        accept     = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                        count_next = 4'd1;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    // Master dropped the request mid-stall: abandon it.
                    state_next = IDLE;
                    count_next = 4'd0;
                end else if (count_reg < WAIT_LIMIT) begin
                    count_next = count_reg + 4'd1;
                end else begin
                    wait_req   = 1'b0;
                    accept     = 1'b1;
                    state_next = DONE;
                    count_next = 4'd0;
                end
            end
            DONE: begin
                wait_req   = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    // A simultaneous read+write is serviced as a write only.
    assign ram_we    = accept & write & in_range & ~reset;
    assign rd_accept = accept & read & ~write & ~reset;

    avalon_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (byteenable),
        .addr  (word_idx),
        .wdata (writedata),
        .rdata (ram_rdata)
    );

    // The RAM output follows its address every cycle, so it is only meaningful
    // in the cycle right after the read was accepted; capture it there.
    assign readdata_int = rd_pending_reg ? (rd_oor_reg ? 32'h0 : ram_rdata)
                                         : readdata_hold_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            count_reg         <= 4'd0;
            rd_pending_reg    <= 1'b0;
            rd_oor_reg        <= 1'b0;
            readdata_hold_reg <= 32'h0;
        end else begin
            state_reg         <= state_next;
            count_reg         <= count_next;
            rd_pending_reg    <= rd_accept;
            rd_oor_reg        <= ~in_range;
            readdata_hold_reg <= readdata_int;
        end
    end

    assign waitrequest = reset | wait_req;
    assign readdata    = reset ? 32'h0 : readdata_int;

    always @(posedge clk) begin
        if (!reset && accept) begin
            assert (!(read && write))
                else $error("avalon_mem_responder: read and write both high, handled as write");
        end
    end

endmodule
